// File: rtl/wb_sram_slave_if.sv
// -----------------------------------------------------------------------------
// wb_sram_pkg / WISHBONE_IF
//
// Purpose: shared access-width type and the Wishbone bundle that connects the
// load/store stage (master) to the data-memory responder (slave).
//
// Handshake: a request is presented by holding cyc & stb high together with
// addr/we/width/data_write. The slave captures the request on the first edge
// it sees cyc & stb while idle and answers with a single-cycle ack; data_read
// is valid only in the ack cycle. Dropping cyc before ack aborts the request.
//
// Signals:
//   addr[31:0]        byte address (master -> slave)
//   we                1 = write, 0 = read (master -> slave)
//   stb, cyc          strobe / cycle valid (master -> slave)
//   width             eDW_B / eDW_H / eDW_W access size (master -> slave)
//   data_write[31:0]  right-aligned write data (master -> slave)
//   data_read[31:0]   right-aligned, zero-extended read data (slave -> master)
//   ack               one-cycle acknowledge (slave -> master)
// -----------------------------------------------------------------------------
package wb_sram_pkg;
  typedef enum logic [1:0] {
    eDW_B = 2'd0,
    eDW_H = 2'd1,
    eDW_W = 2'd2
  } width_e;
endpackage

interface WISHBONE_IF;
  logic [31:0]         addr;
  logic                we;
  logic                stb;
  logic                cyc;
  wb_sram_pkg::width_e width;
  logic [31:0]         data_write;
  logic [31:0]         data_read;
  logic                ack;

  modport master (
    output addr, we, stb, cyc, width, data_write,
    input  data_read, ack
  );

  modport slave (
    input  addr, we, stb, cyc, width, data_write,
    output data_read, ack
  );
endinterface

// File: rtl/wb_sram_slave.sv
// -----------------------------------------------------------------------------
// wb_sram_slave
//
// Purpose: Wishbone responder owning a word-organised RAM. Decodes byte/half/
// word accesses onto byte lanes, returns right-aligned zero-extended read data,
// inserts WAIT_STATES cycles before ack and flags misaligned accesses.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   mem_wb       WISHBONE_IF.slave bus
//   iFaultClr    synchronous clear of oFault (wins over a same-cycle set)
//   oFault       sticky misaligned-access flag
//   dbg_state_o  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module wb_sram_slave
  import wb_sram_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  WISHBONE_IF.slave  mem_wb,
  input  logic       iFaultClr,
  output logic       oFault,
  output logic [1:0] dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          we_q, we_d;
  width_e        width_q, width_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          fault_q, fault_d;

  logic [31:0]   mem [DEPTH];

  function automatic logic is_misaligned(input width_e w, input logic [1:0] off);
    case (w)
      eDW_B:   return 1'b0;
      eDW_H:   return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  // The read is fetched on the edge entering RESP. Coming straight from IDLE
  // (no wait states) the request has not been latched yet, so the live bus is
  // used there; from WAIT the latched copy is used.
  logic [AW+1:0] req_addr;
  logic          req_we;
  width_e        req_width;
  logic [1:0]    req_off;
  logic [31:0]   rd_word;
  logic [31:0]   rd_lane;

  assign req_addr  = (state_q == S_IDLE) ? mem_wb.addr[AW+1:0] : addr_q;
  assign req_we    = (state_q == S_IDLE) ? mem_wb.we           : we_q;
  assign req_width = (state_q == S_IDLE) ? mem_wb.width        : width_q;
  assign req_off   = req_addr[1:0];
  assign rd_word   = mem[req_addr[AW+1:2]];

  always_comb begin
    rd_lane = '0;
    case (req_width)
      eDW_B:   rd_lane = {24'b0, rd_word[{req_off, 3'b000} +: 8]};
      eDW_H:   rd_lane = {16'b0, (req_off[1] ? rd_word[31:16] : rd_word[15:0])};
      default: rd_lane = rd_word;
    endcase
  end

  // Write lanes come only from the latched request.
  logic       misaligned_q;
  logic [3:0] wr_be;
  logic [31:0] wr_data;
  logic       wr_en;

  assign misaligned_q = is_misaligned(width_q, addr_q[1:0]);

  always_comb begin
    wr_be   = '0;
    wr_data = '0;
    case (width_q)
      eDW_B: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      eDW_H: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  assign wr_en = (state_q == S_RESP) && we_q && !misaligned_q;

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    width_d = width_q;
    wdata_d = wdata_q;
    fault_d = fault_q;

    case (state_q)
      S_IDLE: begin
        if (mem_wb.cyc && mem_wb.stb) begin
          addr_d  = mem_wb.addr[AW+1:0];
          we_d    = mem_wb.we;
          width_d = mem_wb.width;
          wdata_d = mem_wb.data_write;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!mem_wb.cyc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ack_d   = (state_d == S_RESP);
    rdata_d = (state_d == S_RESP && !req_we && !is_misaligned(req_width, req_off))
              ? rd_lane : 32'b0;

    if (iFaultClr)                            fault_d = 1'b0;
    else if (state_q == S_RESP && misaligned_q) fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      width_q <= eDW_W;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
    end
  end

  // RAM is not reset, but a write in RESP is dropped if reset hits that edge.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign mem_wb.ack       = ack_q;
  assign mem_wb.data_read = rdata_q;
  assign oFault           = fault_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_wb_sram_slave.sv
`timescale 1ns/1ps
module tb_wb_sram_slave;
  import wb_sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fault_clr;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  width_e      width;
  int          sel;
  int          cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  WISHBONE_IF bus0 ();
  WISHBONE_IF bus3 ();
  WISHBONE_IF bus4 ();

  assign bus0.cyc = cyc && (sel == 0);
  assign bus0.stb = stb && (sel == 0);
  assign bus3.cyc = cyc && (sel == 3);
  assign bus3.stb = stb && (sel == 3);
  assign bus4.cyc = cyc && (sel == 4);
  assign bus4.stb = stb && (sel == 4);
  assign bus0.addr = addr;  assign bus3.addr = addr;  assign bus4.addr = addr;
  assign bus0.we = we;      assign bus3.we = we;      assign bus4.we = we;
  assign bus0.width = width; assign bus3.width = width; assign bus4.width = width;
  assign bus0.data_write = wdata; assign bus3.data_write = wdata; assign bus4.data_write = wdata;

  logic       flt0, flt3, flt4;
  logic [1:0] dbg0, dbg3, dbg4;

  wb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_wb(bus0), .iFaultClr(fault_clr),
    .oFault(flt0), .dbg_state_o(dbg0));
  wb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_wb(bus3), .iFaultClr(fault_clr),
    .oFault(flt3), .dbg_state_o(dbg3));
  wb_sram_slave #(.DEPTH(1024), .WAIT_STATES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_wb(bus4), .iFaultClr(fault_clr),
    .oFault(flt4), .dbg_state_o(dbg4));

  logic        ack_s, fault_s;
  logic [31:0] rd_s;
  logic [1:0]  dbg_s;
  always_comb begin
    ack_s = bus0.ack; rd_s = bus0.data_read; fault_s = flt0; dbg_s = dbg0;
    if (sel == 3) begin ack_s = bus3.ack; rd_s = bus3.data_read; fault_s = flt3; dbg_s = dbg3; end
    if (sel == 4) begin ack_s = bus4.ack; rd_s = bus4.data_read; fault_s = flt4; dbg_s = dbg4; end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One complete access: presents the request at a negedge, counts edges to
  // ack, drops the request in the ack cycle and samples one edge later.
  task automatic do_access(input int s, input logic w, input logic [31:0] a,
                           input width_e wd, input logic [31:0] d,
                           output logic [31:0] rd, output int lat, output logic flt);
    @(negedge clk);
    sel = s; we = w; addr = a; width = wd; wdata = d; cyc = 1'b1; stb = 1'b1;
    lat = 0; rd = '0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack_s) begin
        rd = rd_s;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", {31'b0, ack_s}, 32'd0);
    flt = fault_s;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          s;
    logic        w;
    logic [31:0] a;
    width_e      wd;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int s, input logic w, input logic [31:0] a,
                              input width_e wd, input logic [31:0] d,
                              input logic [31:0] exp_rd, input int exp_lat,
                              input logic exp_flt);
    vec_t v;
    v.s = s; v.w = w; v.a = a; v.wd = wd; v.d = d;
    v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_flt = exp_flt;
    return v;
  endfunction

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp  [3];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd;
    int          lat;
    logic        flt;
    int          t_prev;
    int          acks;
    logic        got;

    // WAIT_STATES=0 instance
    vecs.push_back(mk(0, 1, 32'h10,   eDW_W, 32'hDEADBEEF, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 32'h10,   eDW_W, 32'h0,        32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(0, 1, 32'h20,   eDW_W, 32'h11223344, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 32'h21,   eDW_B, 32'h000000AA, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 32'h20,   eDW_W, 32'h0,        32'h1122AA44, 1, 0));
    vecs.push_back(mk(0, 1, 32'h22,   eDW_H, 32'h00005566, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 32'h20,   eDW_W, 32'h0,        32'h5566AA44, 1, 0));
    vecs.push_back(mk(0, 0, 32'h23,   eDW_B, 32'h0,        32'h00000055, 1, 0));
    vecs.push_back(mk(0, 0, 32'h22,   eDW_H, 32'h0,        32'h00005566, 1, 0));
    vecs.push_back(mk(0, 0, 32'h21,   eDW_B, 32'h0,        32'h000000AA, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1004, eDW_W, 32'hCAFEF00D, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 32'h4,    eDW_W, 32'h0,        32'hCAFEF00D, 1, 0));
    vecs.push_back(mk(0, 1, 32'h30,   eDW_W, 32'h01020304, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 32'h31,   eDW_W, 32'hFFFFFFFF, 32'h0,        1, 1));
    vecs.push_back(mk(0, 0, 32'h30,   eDW_W, 32'h0,        32'h01020304, 1, 1));
    // WAIT_STATES=3 instance
    vecs.push_back(mk(3, 1, 32'h40,   eDW_W, 32'hA0A0A0A0, 32'h0,        4, 0));
    vecs.push_back(mk(3, 1, 32'h44,   eDW_W, 32'h0B0B0B0B, 32'h0,        4, 0));
    vecs.push_back(mk(3, 0, 32'h40,   eDW_W, 32'h0,        32'hA0A0A0A0, 4, 0));
    vecs.push_back(mk(3, 0, 32'h21,   eDW_H, 32'h0,        32'h0,        4, 1));
    vecs.push_back(mk(3, 0, 32'h44,   eDW_B, 32'h0,        32'h0000000B, 4, 1));
    // WAIT_STATES=4 instance
    vecs.push_back(mk(4, 1, 32'h50,   eDW_W, 32'h12345678, 32'h0,        5, 0));
    vecs.push_back(mk(4, 0, 32'h52,   eDW_H, 32'h0,        32'h00001234, 5, 0));

    b2b_addr[0] = 32'h40; b2b_exp[0] = 32'hA0A0A0A0;
    b2b_addr[1] = 32'h44; b2b_exp[1] = 32'h0B0B0B0B;
    b2b_addr[2] = 32'h40; b2b_exp[2] = 32'hA0A0A0A0;

    // reset
    rst_n = 1'b0; fault_clr = 1'b0; sel = 0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; width = eDW_W;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    check("rst_ack",   {31'b0, ack_s},   32'd0);
    check("rst_rdata", rd_s,             32'd0);
    check("rst_fault", {31'b0, fault_s}, 32'd0);
    check("rst_state", {30'b0, dbg_s},   32'd0);

    // table-driven accesses
    for (int i = 0; i < vecs.size(); i++) begin
      do_access(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].d, rd, lat, flt);
      check($sformatf("vec%0d_rdata", i),   rd,             vecs[i].exp_rd);
      check($sformatf("vec%0d_latency", i), lat,            vecs[i].exp_lat);
      check($sformatf("vec%0d_fault", i),   {31'b0, flt},   {31'b0, vecs[i].exp_flt});
    end

    // fault clear pulse
    @(negedge clk); sel = 0; fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    check("fault_clr_dut0", {31'b0, fault_s}, 32'd0);
    sel = 3; #1;
    check("fault_clr_dut3", {31'b0, fault_s}, 32'd0);

    // back-to-back reads, stb held high, WAIT_STATES=3
    @(negedge clk);
    sel = 3; we = 1'b0; width = eDW_W; addr = b2b_addr[0]; cyc = 1'b1; stb = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (ack_s) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("b2b%0d_ack_seen", k), {31'b0, got}, 32'd1);
      check($sformatf("b2b%0d_rdata", k), rd_s, b2b_exp[k]);
      if (k > 0) check($sformatf("b2b%0d_spacing", k), cycle - t_prev, 32'd5);
      t_prev = cycle;
      if (k < 2) addr = b2b_addr[k+1];
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("b2b_no_extra_ack", {31'b0, ack_s}, 32'd0);

    // abort during WAIT on a write, WAIT_STATES=4
    @(negedge clk);
    sel = 4; we = 1'b1; width = eDW_W; addr = 32'h50; wdata = 32'h77777777;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("abort_in_wait", {30'b0, dbg_s}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack_s) acks++;
    end
    check("abort_no_ack", acks, 32'd0);
    do_access(4, 0, 32'h50, eDW_W, 32'h0, rd, lat, flt);
    check("abort_mem_unchanged", rd, 32'h12345678);

    // reset on the edge ending RESP of a write: write dropped, outputs cleared
    @(negedge clk);
    sel = 4; we = 1'b1; width = eDW_W; addr = 32'h50; wdata = 32'h99999999;
    cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack_s) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_resp_ack_seen", {31'b0, got}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_resp_ack",   {31'b0, ack_s}, 32'd0);
    check("rst_resp_rdata", rd_s,           32'd0);
    @(negedge clk); rst_n = 1'b1;

    // reset mid-WAIT on a read: no ack after release
    @(negedge clk);
    sel = 4; we = 1'b0; addr = 32'h50; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rst_wait_state", {30'b0, dbg_s}, 32'd0);
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack_s) acks++;
    end
    check("rst_wait_no_ack", acks, 32'd0);

    // normal read after reset; the write cut by reset must not have landed
    do_access(4, 0, 32'h50, eDW_W, 32'h0, rd, lat, flt);
    check("post_rst_rdata",   rd,  32'h12345678);
    check("post_rst_latency", lat, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
